rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
Parametrised reset sequencer that replaces the fixed single cold-reset counter at board top level. It releases NUM_CH downstream reset domains in order, for example PHY/XGMII, MAC/eth, then KVS/db. It watches per-channel fault inputs such as clock alarm, RX LOS and TX fault. On a fault it re-resets only the faulting channel and every channel after it, then re-sequences them. It also exports fault counters and a heartbeat for the LED bank.

Parameters:
NUM_CH, 3, number of reset domains; channel i depends on channels 0..i-1
COLD_CYCLES, 16384, clocks held in reset after rst or sw_rst_req
STAGE_GAP, 1024, clocks between successive channel releases
HOLD_CYCLES, 4096, clocks the faulting channel's fault must stay clear before re-release
DEBOUNCE, 8, consecutive synced-high clocks needed to accept a fault
CNT_W, 8, width of each saturating fault counter
HB_BIT, 24, free-running counter bit driven on heartbeat

Ports:
clk  in  1  sequencer clock
rst  in  1  reset
fault_in  in  NUM_CH  asynchronous active-high fault per channel
sw_rst_req  in  1  single-cycle request for a full cold restart
ch_rst  out  NUM_CH  active-high reset per domain
ready  out  1  high when all channels are released and no fault is pending
state  out  2  00 COLD, 01 RELEASE, 10 RUN, 11 HOLD
fault_cnt  out  NUM_CH*CNT_W  per-channel accepted-fault count; channel i at [i*CNT_W +: CNT_W]
heartbeat  out  1  blink indication

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high: state=COLD, ch_rst=all 1, ready=0, fault_cnt=0, heartbeat=0. All counters, synchronisers and debouncers are cleared.
- Fault synchronisation: each fault_in passes through a 2-flop synchroniser to give fs[i].
- Debounce: counter db[i] increments while fs[i]=1 and clears when fs[i]=0. An event ev[i] fires once when db[i] reaches DEBOUNCE. It re-arms only after fs[i] returns to 0, so one fault gives one event.
- Fault latency: ch_rst rises on the DEBOUNCE+3-th rising edge after fault_in is first sampled high.
- COLD: count COLD_CYCLES clocks, then go to RELEASE with idx=0.
- Release timing from COLD: ch_rst[i] falls exactly COLD_CYCLES + i*STAGE_GAP edges after the first edge with rst sampled low.
- RELEASE: on entry, ch_rst[idx] goes to 0. After STAGE_GAP clocks, idx increments. When the last channel has been released and a further STAGE_GAP clocks have elapsed, go to RUN and set ready=1.
- RUN: ready=1; hold here until a fault event or sw_rst_req.
- Fault event in RELEASE or RUN:
  - k = lowest index with ev[k].
  - ch_rst[k..NUM_CH-1] go to 1; channels below k are untouched.
  - ready goes to 0 and state goes to HOLD with hk=k.
- Fault event in HOLD: if k < hk, set hk=k, assert the extra resets and restart the hold counter. Events with k >= hk are counted only.
- HOLD: the hold counter advances only while fs[hk]=0 and clears whenever fs[hk]=1. On reaching HOLD_CYCLES, go to RELEASE with idx=hk.
- Fault counting: fault_cnt[i] increments on every ev[i] in any state except COLD. It saturates at 2^CNT_W-1. Simultaneous events each increment their own counter.
- sw_rst_req in RELEASE, RUN or HOLD: go to COLD with ch_rst=all 1 and ready=0. COLD restarts from 0 and fault_cnt is preserved. sw_rst_req in COLD restarts the COLD count.
- Precedence: rst > sw_rst_req > fault event > timer expiry, all evaluated in the same cycle.
- heartbeat = free_cnt[HB_BIT] when ready=1, else 0. free_cnt runs continuously from rst.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
Common parameters unless stated: NUM_CH=3, COLD_CYCLES=16, STAGE_GAP=4, HOLD_CYCLES=8, DEBOUNCE=3, CNT_W=2, HB_BIT=3.
1. Reset release: deassert rst with no faults. ch_rst[0], [1], [2] fall at edges 16, 20, 24; ready rises at 28; state=10; heartbeat toggles every 8 clocks.
2. Glitch filtering: in RUN, pulse fault_in[1] high for 2 clocks. No change to ch_rst, ready stays 1, fault_cnt[1]=0.
3. Mid-chain fault: in RUN, hold fault_in[1] high for 10 clocks.
   - ch_rst = 3'b110 at edge +6; ch_rst[0] stays 0; fault_cnt[1]=1; state=11.
   - After the fault clears plus 2 clocks of sync, plus 8 clocks of hold, ch_rst[1] falls; 4 clocks later ch_rst[2] falls; 4 clocks later ready=1.
4. Simultaneous faults: in RUN, raise fault_in[0] and fault_in[2] together. ch_rst=3'b111; fault_cnt[0]=1 and fault_cnt[2]=1. Release restarts from idx=0.
5. Escalation and saturation:
   - During HOLD on channel 2, a fault on channel 1 makes ch_rst[1]=1 and restarts hold with hk=1.
   - After 5 separate faults on channel 0, fault_cnt[0]=3.
6. Restart requests: sw_rst_req during RELEASE gives all ch_rst=1, state=00, release at 16 clocks again, with counts preserved. rst asserted mid-HOLD gives all outputs at reset values and fault_cnt=0 on the next edge.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: parametrised reset sequencer for NUM_CH dependent reset domains.
//
// Releases the domains in order after a cold count, watches one asynchronous
// fault input per domain, and on a debounced fault re-resets the faulting
// domain plus every domain after it. Once the fault has stayed clear for
// HOLD_CYCLES, those domains are released again in order.
//
// Ports:
//   clk         sequencer clock
//   rst         synchronous active-high reset
//   fault_in    per-channel asynchronous active-high fault
//   sw_rst_req  single-cycle request for a full cold restart
//   ch_rst      per-domain active-high reset (registered)
//   ready       all domains released and no fault pending (registered)
//   state       00 COLD, 01 RELEASE, 10 RUN, 11 HOLD
//   fault_cnt   per-channel saturating accepted-fault count, channel i at [i*CNT_W +: CNT_W]
//   heartbeat   free-running blink, gated by ready (registered)
module rst_seq #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned COLD_CYCLES = 16384,
    parameter int unsigned STAGE_GAP   = 1024,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned DEBOUNCE    = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned HB_BIT      = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       fault_in,
    input  logic                    sw_rst_req,
    output logic [NUM_CH-1:0]       ch_rst,
    output logic                    ready,
    output logic [1:0]              state,
    output logic [NUM_CH*CNT_W-1:0] fault_cnt,
    output logic                    heartbeat
);

    localparam int unsigned TMR_MAX_A = (COLD_CYCLES > STAGE_GAP) ? COLD_CYCLES : STAGE_GAP;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > HOLD_CYCLES) ? TMR_MAX_A : HOLD_CYCLES;
    localparam int unsigned TW        = $clog2(TMR_MAX + 1);
    localparam int unsigned IW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Debounce counter saturates one above DEBOUNCE so the event fires once.
    localparam int unsigned DW        = $clog2(DEBOUNCE + 2);

    typedef enum logic [1:0] {
        StCold    = 2'b00,
        StRelease = 2'b01,
        StRun     = 2'b10,
        StHold    = 2'b11
    } st_e;

    st_e                  st_q, st_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        hk_q, hk_d;
    logic [IW-1:0]        rs_q, rs_d;
    logic [NUM_CH-1:0]    ch_rst_q, ch_rst_d;
    logic                 ready_q, ready_d;
    logic                 heartbeat_q, heartbeat_d;
    logic [HB_BIT:0]      free_cnt_q, free_cnt_d;

    logic [NUM_CH-1:0]    sync1_q, fs_q;
    logic [DW-1:0]        db_q [NUM_CH];
    logic [DW-1:0]        db_d [NUM_CH];
    logic [CNT_W-1:0]     fcnt_q [NUM_CH];
    logic [CNT_W-1:0]     fcnt_d [NUM_CH];

    logic [NUM_CH-1:0]    ev;
    logic                 any_ev;
    logic [IW-1:0]        k;
    logic [NUM_CH-1:0]    kmask;

    // ------------------------------------------------------------------
    // Debounce, event detection and fault counting
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            db_d[i] = '0;
            if (fs_q[i]) begin
                if (db_q[i] == DW'(DEBOUNCE + 1)) begin
                    db_d[i] = db_q[i];
                end else begin
                    db_d[i] = db_q[i] + 1'b1;
                end
            end
            ev[i] = (db_q[i] == DW'(DEBOUNCE));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if ((st_q != StCold) && ev[i] && (fcnt_q[i] != {CNT_W{1'b1}})) begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    // Lowest faulting channel and the mask of it and every channel after it.
    always_comb begin
        k      = '0;
        any_ev = |ev;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ev[i]) begin
                k = IW'(i);
            end
        end
        kmask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            kmask[i] = (i >= int'(k));
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        st_d     = st_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        hk_d     = hk_q;
        rs_d     = rs_q;
        ch_rst_d = ch_rst_q;
        ready_d  = ready_q;

        if (sw_rst_req) begin
            st_d     = StCold;
            tmr_d    = '0;
            ch_rst_d = '1;
            ready_d  = 1'b0;
        end else begin
            unique case (st_q)
                StCold: begin
                    ch_rst_d = '1;
                    ready_d  = 1'b0;
                    if (tmr_q == TW'(COLD_CYCLES - 1)) begin
                        st_d        = StRelease;
                        tmr_d       = '0;
                        idx_d       = '0;
                        ch_rst_d[0] = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (any_ev) begin
                        st_d     = StHold;
                        tmr_d    = '0;
                        hk_d     = k;
                        ch_rst_d = ch_rst_q | kmask;
                        ready_d  = 1'b0;
                        // Channels above idx were never released; if the fault sits
                        // above them, re-release has to start at the first one still
                        // held so the ordering is kept.
                        rs_d     = (k <= idx_q) ? k : idx_q + 1'b1;
                    end else if (tmr_q == TW'(STAGE_GAP - 1)) begin
                        tmr_d = '0;
                        if (idx_q == IW'(NUM_CH - 1)) begin
                            st_d    = StRun;
                            ready_d = 1'b1;
                        end else begin
                            idx_d           = idx_q + 1'b1;
                            ch_rst_d[idx_d] = 1'b0;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end

                StRun: begin
                    ready_d = 1'b1;
                    if (any_ev) begin
                        st_d     = StHold;
                        tmr_d    = '0;
                        hk_d     = k;
                        rs_d     = k;
                        ch_rst_d = ch_rst_q | kmask;
                        ready_d  = 1'b0;
                    end
                end

                StHold: begin
                    ready_d = 1'b0;
                    if (any_ev && (k < hk_q)) begin
                        // Escalate to the lower channel; higher events are only counted.
                        hk_d     = k;
                        rs_d     = (k < rs_q) ? k : rs_q;
                        tmr_d    = '0;
                        ch_rst_d = ch_rst_q | kmask;
                    end else if (fs_q[hk_q]) begin
                        tmr_d = '0;
                    end else if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
                        st_d           = StRelease;
                        tmr_d          = '0;
                        idx_d          = rs_q;
                        ch_rst_d[rs_q] = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end

                default: begin
                    st_d = StCold;
                end
            endcase
        end

        free_cnt_d  = free_cnt_q + 1'b1;
        heartbeat_d = ready_d & free_cnt_d[HB_BIT];
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StCold;
            tmr_q       <= '0;
            idx_q       <= '0;
            hk_q        <= '0;
            rs_q        <= '0;
            ch_rst_q    <= '1;
            ready_q     <= 1'b0;
            heartbeat_q <= 1'b0;
            free_cnt_q  <= '0;
            sync1_q     <= '0;
            fs_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_q[i]   <= '0;
                fcnt_q[i] <= '0;
            end
        end else begin
            st_q        <= st_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            hk_q        <= hk_d;
            rs_q        <= rs_d;
            ch_rst_q    <= ch_rst_d;
            ready_q     <= ready_d;
            heartbeat_q <= heartbeat_d;
            free_cnt_q  <= free_cnt_d;
            sync1_q     <= fault_in;
            fs_q        <= sync1_q;
            for (int i = 0; i < NUM_CH; i++) begin
                db_q[i]   <= db_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fault_cnt[i*CNT_W +: CNT_W] = fcnt_q[i];
        end
    end

    assign ch_rst    = ch_rst_q;
    assign ready     = ready_q;
    assign state     = st_q;
    assign heartbeat = heartbeat_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq with small timing parameters.
// Edge counter n counts rising edges since rst was released, so the free
// counter equals n and heartbeat is expected as ready & n[3].
module tb_rst_seq;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       fault_in;
    logic                    sw_rst_req;
    logic [NUM_CH-1:0]       ch_rst;
    logic                    ready;
    logic [1:0]              state;
    logic [NUM_CH*CNT_W-1:0] fault_cnt;
    logic                    heartbeat;

    int unsigned n;
    int          checks;
    int          errors;

    rst_seq #(
        .NUM_CH      (NUM_CH),
        .COLD_CYCLES (16),
        .STAGE_GAP   (4),
        .HOLD_CYCLES (8),
        .DEBOUNCE    (3),
        .CNT_W       (CNT_W),
        .HB_BIT      (3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fault_in   (fault_in),
        .sw_rst_req (sw_rst_req),
        .ch_rst     (ch_rst),
        .ready      (ready),
        .state      (state),
        .fault_cnt  (fault_cnt),
        .heartbeat  (heartbeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        logic [2:0]  fault;
        logic [2:0]  ch;
        logic        rdy;
        logic [1:0]  st;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic wait_to(input int unsigned at);
        while (n < at) tick();
    endtask

    task automatic chk(input string name, input logic [2:0] ech, input logic erdy,
                       input logic [1:0] est, input logic [5:0] ecnt);
        logic [31:0] nv;
        logic        ehb;
        nv  = n;
        ehb = erdy & nv[3];
        checks = checks + 1;
        if (ch_rst !== ech || ready !== erdy || state !== est || fault_cnt !== ecnt ||
            heartbeat !== ehb) begin
            errors = errors + 1;
            $display("FAIL %s @edge %0d: got ch_rst=%b ready=%b state=%b cnt=%b hb=%b, want ch_rst=%b ready=%b state=%b cnt=%b hb=%b",
                     name, n, ch_rst, ready, state, fault_cnt, heartbeat,
                     ech, erdy, est, ecnt, ehb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        int unsigned t;
        int          guard;

        checks = 0;
        errors = 0;
        n      = 0;

        // Reset release, glitch filter and mid-chain fault on one timeline.
        vecs[0]  = '{1,  3'b000, 3'b111, 1'b0, 2'b00, 6'b000000};
        vecs[1]  = '{15, 3'b000, 3'b111, 1'b0, 2'b00, 6'b000000};
        vecs[2]  = '{16, 3'b000, 3'b110, 1'b0, 2'b01, 6'b000000};
        vecs[3]  = '{19, 3'b000, 3'b110, 1'b0, 2'b01, 6'b000000};
        vecs[4]  = '{20, 3'b000, 3'b100, 1'b0, 2'b01, 6'b000000};
        vecs[5]  = '{23, 3'b000, 3'b100, 1'b0, 2'b01, 6'b000000};
        vecs[6]  = '{24, 3'b000, 3'b000, 1'b0, 2'b01, 6'b000000};
        vecs[7]  = '{27, 3'b000, 3'b000, 1'b0, 2'b01, 6'b000000};
        vecs[8]  = '{28, 3'b000, 3'b000, 1'b1, 2'b10, 6'b000000};
        vecs[9]  = '{30, 3'b010, 3'b000, 1'b1, 2'b10, 6'b000000};
        vecs[10] = '{32, 3'b000, 3'b000, 1'b1, 2'b10, 6'b000000};
        vecs[11] = '{40, 3'b010, 3'b000, 1'b1, 2'b10, 6'b000000};
        vecs[12] = '{45, 3'b010, 3'b000, 1'b1, 2'b10, 6'b000000};
        vecs[13] = '{46, 3'b010, 3'b110, 1'b0, 2'b11, 6'b000100};
        vecs[14] = '{50, 3'b000, 3'b110, 1'b0, 2'b11, 6'b000100};
        vecs[15] = '{59, 3'b000, 3'b110, 1'b0, 2'b11, 6'b000100};
        vecs[16] = '{60, 3'b000, 3'b100, 1'b0, 2'b01, 6'b000100};
        vecs[17] = '{64, 3'b000, 3'b000, 1'b0, 2'b01, 6'b000100};
        vecs[18] = '{67, 3'b000, 3'b000, 1'b0, 2'b01, 6'b000100};
        vecs[19] = '{68, 3'b000, 3'b000, 1'b1, 2'b10, 6'b000100};

        // Reset, with faults asserted to show reset dominates.
        rst        = 1'b1;
        fault_in   = 3'b111;
        sw_rst_req = 1'b0;
        repeat (4) tick();
        n = 0;
        chk("reset_state", 3'b111, 1'b0, 2'b00, 6'b000000);
        fault_in = 3'b000;
        rst      = 1'b0;

        for (int i = 0; i < 20; i++) begin
            wait_to(vecs[i].at);
            chk($sformatf("vec%0d", i), vecs[i].ch, vecs[i].rdy, vecs[i].st, vecs[i].cnt);
            fault_in = vecs[i].fault;
        end

        // Simultaneous faults on channels 0 and 2: everything re-resets from idx 0.
        wait_to(70);
        fault_in = 3'b101;
        wait_to(75);
        chk("simul_before", 3'b000, 1'b1, 2'b10, 6'b000100);
        tick();
        chk("simul_hit", 3'b111, 1'b0, 2'b11, 6'b010101);
        wait_to(80);
        fault_in = 3'b000;
        wait_to(89);
        chk("simul_hold", 3'b111, 1'b0, 2'b11, 6'b010101);
        tick();
        chk("simul_rel0", 3'b110, 1'b0, 2'b01, 6'b010101);
        wait_to(98);
        chk("simul_rel2", 3'b000, 1'b0, 2'b01, 6'b010101);
        wait_to(102);
        chk("simul_ready", 3'b000, 1'b1, 2'b10, 6'b010101);

        // Escalation: hold on channel 2, then channel 1 faults.
        wait_to(110);
        fault_in = 3'b100;
        wait_to(116);
        chk("esc_hk2", 3'b100, 1'b0, 2'b11, 6'b100101);
        fault_in = 3'b110;
        wait_to(121);
        chk("esc_pre", 3'b100, 1'b0, 2'b11, 6'b100101);
        tick();
        chk("esc_hk1", 3'b110, 1'b0, 2'b11, 6'b101001);
        wait_to(124);
        fault_in = 3'b000;
        wait_to(133);
        chk("esc_hold", 3'b110, 1'b0, 2'b11, 6'b101001);
        tick();
        chk("esc_rel1", 3'b100, 1'b0, 2'b01, 6'b101001);
        wait_to(142);
        chk("esc_ready", 3'b000, 1'b1, 2'b10, 6'b101001);

        // Saturation: five separate faults on channel 0.
        for (int p = 0; p < 5; p++) begin
            fault_in = 3'b001;
            repeat (4) tick();
            fault_in = 3'b000;
            repeat (4) tick();
        end
        chk("sat_hold", 3'b111, 1'b0, 2'b11, 6'b101011);
        guard = 0;
        while (!ready && guard < 300) begin
            tick();
            guard = guard + 1;
        end
        checks = checks + 1;
        if (!ready) begin
            errors = errors + 1;
            $display("FAIL sat_recover: ready=%b after %0d cycles, want 1", ready, guard);
        end
        chk("sat_run", 3'b000, 1'b1, 2'b10, 6'b101011);

        // Heartbeat follows free counter bit 3 while ready.
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("heartbeat", 3'b000, 1'b1, 2'b10, 6'b101011);
        end

        // Software restart from RUN, then again from RELEASE.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        s = n;
        chk("sw_cold", 3'b111, 1'b0, 2'b00, 6'b101011);
        wait_to(s + 15);
        chk("sw_cold_end", 3'b111, 1'b0, 2'b00, 6'b101011);
        tick();
        chk("sw_rel0", 3'b110, 1'b0, 2'b01, 6'b101011);
        wait_to(s + 18);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        t = n;
        chk("sw_in_rel", 3'b111, 1'b0, 2'b00, 6'b101011);
        wait_to(t + 15);
        chk("sw2_cold_end", 3'b111, 1'b0, 2'b00, 6'b101011);
        tick();
        chk("sw2_rel0", 3'b110, 1'b0, 2'b01, 6'b101011);

        // Fault during RELEASE, then rst in HOLD.
        wait_to(t + 21);
        fault_in = 3'b001;
        wait_to(t + 27);
        chk("rel_fault", 3'b111, 1'b0, 2'b11, 6'b101011);
        rst = 1'b1;
        tick();
        chk("rst_in_hold", 3'b111, 1'b0, 2'b00, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
